// File: rtl/adc_seq_defs.sv
// Shared definitions for the multi-channel ADC capture sequencer.
// State encodings, on/off levels and counter width helper.
package adc_seq_defs;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_WAIT_DONE = 2'b01,
    ST_RESET     = 2'b10,
    ST_REARM     = 2'b11
  } ch_state_t;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  // Bits needed to count 0 .. n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adc_ch_ctrl.sv
// Single-channel ADC done/valid/reset sequencer with
// no-done timeout and programmable reset pulse length.
module adc_ch_ctrl
  import adc_seq_defs::*;
#(
  parameter int DATA_W         = 14,
  parameter int RST_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              oneshot,
  input  logic              start,
  input  logic              mask,
  input  logic              done,
  input  logic [DATA_W-1:0] sample,
  input  logic              clear_err,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              adc_rst,
  output logic              err,
  output ch_state_t         state
);

  localparam int TW = cnt_w(TIMEOUT_CYCLES);
  localparam int RW = cnt_w(RST_CYCLES);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RST_LOAD = RW'(RST_CYCLES - 1);

  logic          done_q;
  logic [TW-1:0] timer;
  logic [RW-1:0] rcnt;
  logic          rise;

  assign rise = done && !done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      done_q  <= OFF;
      timer   <= '0;
      rcnt    <= '0;
      data    <= '0;
      valid   <= OFF;
      adc_rst <= OFF;
      err     <= OFF;
    end else begin
      done_q <= done;
      valid  <= OFF;
      if (clear_err) err <= OFF;
      if (!enable) begin
        state   <= ST_IDLE;
        adc_rst <= OFF;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (mask && (!oneshot || start)) begin
              state <= ST_WAIT_DONE;
              timer <= '0;
            end
          end
          ST_WAIT_DONE: begin
            // A done edge wins over a coincident timeout.
            if (rise) begin
              data    <= sample;
              valid   <= ON;
              adc_rst <= ON;
              rcnt    <= RST_LOAD;
              state   <= ST_RESET;
            end else if (TO_EN && timer == TO_LAST) begin
              err     <= ON;
              adc_rst <= ON;
              rcnt    <= RST_LOAD;
              state   <= ST_RESET;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          ST_RESET: begin
            if (rcnt == '0) begin
              adc_rst <= OFF;
              state   <= ST_REARM;
            end else begin
              rcnt <= rcnt - 1'b1;
            end
          end
          ST_REARM: begin
            // Hold here while a stale done is still high.
            if (!done) begin
              if (!oneshot && mask) begin
                state <= ST_WAIT_DONE;
                timer <= '0;
              end else begin
                state <= ST_IDLE;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/adc_capture_sequencer.sv
// Multi-channel ADC capture sequencer: per-channel FSMs plus
// frame-completion tracking across the masked channels.
module adc_capture_sequencer
  import adc_seq_defs::*;
#(
  parameter int NUM_CH         = 4,
  parameter int DATA_W         = 14,
  parameter int RST_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     adc_clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     oneshot,
  input  logic                     start,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic [NUM_CH-1:0]        done,
  input  logic [NUM_CH*DATA_W-1:0] adc_data,
  input  logic                     clear_err,
  output logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_valid,
  output logic [NUM_CH-1:0]        adc_rst,
  output logic [NUM_CH-1:0]        timeout_err,
  output logic                     frame_valid,
  output logic [NUM_CH*2-1:0]      ch_state
);

  logic [NUM_CH-1:0] captured;
  logic              frame_hit;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_state_t st;

    adc_ch_ctrl #(
      .DATA_W         (DATA_W),
      .RST_CYCLES     (RST_CYCLES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_ch (
      .clk       (adc_clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .oneshot   (oneshot),
      .start     (start),
      .mask      (ch_mask[i]),
      .done      (done[i]),
      .sample    (adc_data[i*DATA_W +: DATA_W]),
      .clear_err (clear_err),
      .data      (ch_data[i*DATA_W +: DATA_W]),
      .valid     (ch_valid[i]),
      .adc_rst   (adc_rst[i]),
      .err       (timeout_err[i]),
      .state     (st)
    );

    assign ch_state[i*2 +: 2] = st;
  end

  assign frame_hit = (ch_mask != '0) &&
    (((captured | ch_valid) & ch_mask) == ch_mask);

  // Captures landing in the completing cycle seed the next frame.
  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      captured    <= '0;
      frame_valid <= OFF;
    end else begin
      frame_valid <= frame_hit;
      captured    <= frame_hit ? ch_valid : (captured | ch_valid);
    end
  end

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Self-checking bench for adc_capture_sequencer: vector table,
// capture scoreboard and hand-written corner sequences.
module tb_adc_capture_sequencer;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 14;
  localparam int RST_CYCLES = 2;
  localparam int TIMEOUT_CYCLES = 16;

  logic adc_clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic oneshot = 1'b0;
  logic start = 1'b0;
  logic clear_err = 1'b0;
  logic [NUM_CH-1:0] ch_mask = '0;
  logic [NUM_CH-1:0] done = '0;
  logic [NUM_CH*DATA_W-1:0] adc_data = '0;

  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0] ch_valid;
  logic [NUM_CH-1:0] adc_rst;
  logic [NUM_CH-1:0] timeout_err;
  logic frame_valid;
  logic [NUM_CH*2-1:0] ch_state;

  adc_capture_sequencer #(
    .NUM_CH         (NUM_CH),
    .DATA_W         (DATA_W),
    .RST_CYCLES     (RST_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .adc_clk     (adc_clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .oneshot     (oneshot),
    .start       (start),
    .ch_mask     (ch_mask),
    .done        (done),
    .adc_data    (adc_data),
    .clear_err   (clear_err),
    .ch_data     (ch_data),
    .ch_valid    (ch_valid),
    .adc_rst     (adc_rst),
    .timeout_err (timeout_err),
    .frame_valid (frame_valid),
    .ch_state    (ch_state)
  );

  always #5 adc_clk = ~adc_clk;

  typedef struct {
    int ch;
    logic [DATA_W-1:0] data;
  } exp_t;

  typedef struct {
    int ch;
    logic [DATA_W-1:0] data;
    int hold;
    int exp_rst;
    int exp_rearm;
  } vec_t;

  int checks = 0;
  int errors = 0;
  bit trunc_ok = 1'b0;
  exp_t sb[$];
  exp_t mon_e;
  int rlen[NUM_CH];
  vec_t vt[4];
  int rst_cnt;
  int rearm_cnt;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge adc_clk);
    #1;
  endtask

  task automatic tickf(input string name, input logic exp_fv);
    tick();
    chk(name, frame_valid, exp_fv);
  endtask

  task automatic fire(input int ch, input logic [DATA_W-1:0] d);
    adc_data[ch*DATA_W +: DATA_W] = d;
    done[ch] = 1'b1;
    sb.push_back('{ch, d});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  function automatic logic [1:0] st(input int ch);
    return ch_state[ch*2 +: 2];
  endfunction

  // Scoreboard and reset-pulse-length monitor.
  always @(negedge adc_clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) rlen[i] = 0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_valid[i]) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid ch%0d: got 1 expected 0", i);
          end else begin
            mon_e = sb.pop_front();
            chk("valid_ch", 64'(i), 64'(mon_e.ch));
            chk("valid_data", 64'(ch_data[i*DATA_W +: DATA_W]),
                64'(mon_e.data));
          end
        end
        if (adc_rst[i]) begin
          rlen[i]++;
        end else if (rlen[i] != 0) begin
          if (!trunc_ok) chk("rst_len", 64'(rlen[i]), 64'(RST_CYCLES));
          rlen[i] = 0;
        end
      end
    end
  end

  initial begin
    vt[0] = '{0, 14'h1A5, 1, 2, 1};
    vt[1] = '{1, 14'h2B7, 13, 2, 11};
    vt[2] = '{2, 14'h3FFF, 2, 2, 1};
    vt[3] = '{3, 14'h0001, 5, 2, 3};

    #2;
    chk("rst_state", 64'(ch_state), 0);
    chk("rst_adc_rst", 64'(adc_rst), 0);
    chk("rst_valid", 64'(ch_valid), 0);
    chk("rst_data", 64'(ch_data), 0);
    chk("rst_err", 64'(timeout_err), 0);
    chk("rst_frame", 64'(frame_valid), 0);
    #1;
    rst_n = 1'b1;

    // Continuous capture and stale-done vectors.
    for (int v = 0; v < 4; v++) begin
      enable = 1'b0;
      tick();
      ch_mask = 4'(1 << vt[v].ch);
      oneshot = 1'b0;
      enable = 1'b1;
      tick();
      chk("vec_wait", 64'(st(vt[v].ch)), 2'b01);
      fire(vt[v].ch, vt[v].data);
      tick();
      chk("vec_reset", 64'(st(vt[v].ch)), 2'b10);
      chk("vec_valid", 64'(ch_valid[vt[v].ch]), 1);
      chk("vec_data", 64'(ch_data[vt[v].ch*DATA_W +: DATA_W]),
          64'(vt[v].data));
      rst_cnt = int'(adc_rst[vt[v].ch]);
      rearm_cnt = 0;
      for (int t = 1; t <= vt[v].hold + 4; t++) begin
        done[vt[v].ch] = (t < vt[v].hold);
        tick();
        rst_cnt += int'(adc_rst[vt[v].ch]);
        if (st(vt[v].ch) == 2'b11) rearm_cnt++;
      end
      chk("vec_rst_cycles", 64'(rst_cnt), 64'(vt[v].exp_rst));
      chk("vec_rearm_cycles", 64'(rearm_cnt), 64'(vt[v].exp_rearm));
      chk("vec_rewait", 64'(st(vt[v].ch)), 2'b01);
    end

    // Timeout on channel 2, clear, then clear vs new timeout.
    enable = 1'b0;
    tick();
    ch_mask = 4'b0100;
    enable = 1'b1;
    tick();
    chk("to_wait", 64'(st(2)), 2'b01);
    repeat (15) tick();
    chk("to_early", 64'(timeout_err[2]), 0);
    tick();
    chk("to_err", 64'(timeout_err[2]), 1);
    chk("to_adc_rst", 64'(adc_rst[2]), 1);
    chk("to_state", 64'(st(2)), 2'b10);
    tick();
    tick();
    chk("to_rearm", 64'(st(2)), 2'b11);
    tick();
    chk("to_rewait", 64'(st(2)), 2'b01);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("to_clear", 64'(timeout_err[2]), 0);
    repeat (14) tick();
    chk("to_pre2", 64'(timeout_err[2]), 0);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("to_set_wins", 64'(timeout_err[2]), 1);
    tick();
    tick();
    chk("to_rearm2", 64'(st(2)), 2'b11);
    enable = 1'b0;
    tick();

    // Frame completion with a carried channel-0 capture.
    do_reset();
    ch_mask = 4'b1011;
    enable = 1'b1;
    tickf("fr_arm", 1'b0);
    fire(0, 14'h111);
    tickf("fr_c0", 1'b0);
    done = '0;
    repeat (3) tickf("fr_gap0", 1'b0);
    fire(1, 14'h222);
    tickf("fr_c1", 1'b0);
    done = '0;
    repeat (3) tickf("fr_gap1", 1'b0);
    fire(0, 14'h333);
    fire(3, 14'h444);
    tickf("fr_c03", 1'b0);
    done = '0;
    tickf("fr_pulse", 1'b1);
    tickf("fr_after", 1'b0);
    tickf("fr_idle", 1'b0);
    fire(1, 14'h555);
    tickf("fr2_c1", 1'b0);
    done = '0;
    tickf("fr2_pulse", 1'b1);
    tickf("fr2_after", 1'b0);
    enable = 1'b0;
    tick();

    // One-shot mode.
    oneshot = 1'b1;
    ch_mask = 4'b0001;
    enable = 1'b1;
    tick();
    tick();
    chk("os_nostart", 64'(st(0)), 2'b00);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("os_armed", 64'(st(0)), 2'b01);
    fire(0, 14'h0AB);
    tick();
    done = '0;
    tick();
    tick();
    chk("os_rearm", 64'(st(0)), 2'b11);
    tick();
    chk("os_idle", 64'(st(0)), 2'b00);
    repeat (2) begin
      done[0] = 1'b1;
      tick();
      done[0] = 1'b0;
      tick();
      tick();
    end
    chk("os_stay_idle", 64'(st(0)), 2'b00);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("os_rearmed", 64'(st(0)), 2'b01);

    // Asynchronous reset during RESET.
    oneshot = 1'b0;
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    fire(0, 14'h1234);
    tick();
    done = '0;
    chk("ar_in_reset", 64'(adc_rst[0]), 1);
    trunc_ok = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_adc_rst", 64'(adc_rst), 0);
    chk("ar_state", 64'(ch_state), 0);
    chk("ar_data", 64'(ch_data), 0);
    chk("ar_valid", 64'(ch_valid), 0);
    sb.delete();
    #3;
    rst_n = 1'b1;

    // Enable drop during RESET truncates the pulse.
    tick();
    chk("en_wait", 64'(st(0)), 2'b01);
    fire(0, 14'h2ABC);
    tick();
    done = '0;
    chk("en_in_reset", 64'(adc_rst[0]), 1);
    enable = 1'b0;
    tick();
    chk("en_trunc", 64'(adc_rst[0]), 0);
    chk("en_idle", 64'(st(0)), 2'b00);
    chk("en_hold_data", 64'(ch_data[DATA_W-1:0]), 64'(14'h2ABC));
    tick();
    tick();
    trunc_ok = 1'b0;

    chk("sb_empty", 64'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_capture_sequencer.md
Name: adc_capture_sequencer

Overview:
- Multi-channel, parametrised successor to the single-channel ADC done/valid/reset FSM.
- Runs one synchronous state machine per channel on adc_clk. Each machine:
  - detects the ADC done rising edge;
  - latches the sample and pulses valid;
  - drives the ADC reset for a programmable number of cycles;
  - re-arms, in continuous or one-shot mode.
- Adds a per-channel no-done timeout with a sticky error, and a frame-complete pulse across the masked channels.
- Sits between the ADC front-end interfaces and the SPGD metric/accumulator logic.

Parameters:
- NUM_CH, 4, number of ADC channels.
- DATA_W, 14, sample width per channel.
- RST_CYCLES, 2, ADC reset pulse length in cycles; range 1 to 255.
- TIMEOUT_CYCLES, 1024, maximum cycles in WAIT_DONE before a timeout; 0 disables the timeout.

Ports:
- adc_clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  global run; low forces every channel to IDLE synchronously.
- oneshot  in  1  0 = continuous re-arm, 1 = re-arm only on start.
- start  in  1  single-cycle arm pulse, used in one-shot mode.
- ch_mask  in  NUM_CH  channels that participate in frame completion and are allowed to run.
- done  in  NUM_CH  per-channel conversion done, synchronous to adc_clk.
- adc_data  in  NUM_CH*DATA_W  packed raw samples; channel i occupies bits [i*DATA_W +: DATA_W].
- clear_err  in  1  clears all sticky timeout flags.
- ch_data  out  NUM_CH*DATA_W  latched samples, same packing as adc_data.
- ch_valid  out  NUM_CH  one-cycle pulse per captured sample.
- adc_rst  out  NUM_CH  active-high ADC reset pulse.
- timeout_err  out  NUM_CH  sticky timeout flags.
- frame_valid  out  1  one-cycle pulse when every masked channel has captured once.
- ch_state  out  NUM_CH*2  current state per channel, for debug.

Behaviour:

Reset (rst_n low, asynchronous):
- All outputs go to 0 and every channel goes to IDLE.
- done_q (the previous-cycle copy of done) = 0, all counters = 0, captured bitmap = 0.

Per-channel states:
- Encoding: IDLE=00, WAIT_DONE=01, RESET=10, REARM=11.
- IDLE:
  - adc_rst = 0.
  - Go to WAIT_DONE when enable && ch_mask[i] && (!oneshot || start).
  - The timeout timer is cleared on entry to WAIT_DONE.
- WAIT_DONE:
  - Rising edge: done[i]=1 while done_q[i]=0.
  - On a rising edge at clock edge k:
    - ch_data slice <= adc_data slice;
    - ch_valid[i]=1 for exactly one cycle after edge k;
    - adc_rst[i]=1 from edge k;
    - go to RESET with the reset counter loaded to RST_CYCLES-1.
  - Timeout: when TIMEOUT_CYCLES != 0 and the timer reaches TIMEOUT_CYCLES-1 with no edge, set timeout_err[i], raise adc_rst[i] and go to RESET. No ch_valid pulse is produced.
  - A done edge in the same cycle as the timeout wins: capture happens and no error is set.
- RESET:
  - adc_rst[i] stays high for exactly RST_CYCLES cycles in total.
  - When the counter reaches 0, adc_rst[i] drops and the channel goes to REARM.
  - done edges during RESET are ignored.
- REARM:
  - Wait until done[i]=0. This blocks a stale high done from re-triggering.
  - Then go to WAIT_DONE if !oneshot, else to IDLE.

Global rules:
- enable low: every channel goes to IDLE on the next edge.
  - adc_rst and ch_valid are cleared.
  - ch_data and timeout_err are held.
  - A reset pulse in progress is truncated.
- ch_mask[i] falling while a channel is running: that channel finishes its current transaction and then parks in IDLE.
- done_q is updated every cycle in every state.

Frame logic:
- The captured bitmap sets bit i on ch_valid[i].
- When (bitmap | ch_valid) & ch_mask == ch_mask and ch_mask != 0:
  - frame_valid pulses one cycle later;
  - the bitmap clears, except for bits whose ch_valid is asserted in the clearing cycle; those carry into the next frame.
- Timed-out channels never complete a frame.

Error flags:
- timeout_err set wins over a simultaneous clear_err.

Decomposition:
- Shared package/header adc_seq_defs holds:
  - state encodings;
  - the ON/OFF constants;
  - a clog2-based width function for the timer and reset counters.
- Natural sub-module: adc_ch_ctrl, a single-channel FSM with its timer and reset counter.
  - Instantiated NUM_CH times under a generate loop.
  - The top level holds the frame bitmap, frame_valid and the data packing.

Test Plan:
- Continuous capture, NUM_CH=4, RST_CYCLES=2:
  - Stimulus: enable=1, oneshot=0, ch_mask=4'hF; raise done[0] with adc_data slice0=14'h1A5.
  - Response: ch_data slice0=14'h1A5; ch_valid[0] high 1 cycle; adc_rst[0] high exactly 2 cycles; REARM, then WAIT_DONE once done falls.
- Stale done:
  - Stimulus: hold done[1]=1 through RESET and for 10 cycles after.
  - Response: no second ch_valid[1]; channel stays in REARM (11) until done[1]=0.
- Timeout, TIMEOUT_CYCLES=16:
  - Stimulus: no done on channel 2.
  - Response: timeout_err[2]=1 after 16 cycles in WAIT_DONE; adc_rst[2] pulses 2 cycles; no ch_valid[2]. clear_err then clears the flag. clear_err asserted in the same cycle as a new timeout leaves the flag set.
- Frame:
  - Stimulus: ch_mask=4'b1011; channels 0, 1 and 3 capture on different cycles.
  - Response: frame_valid pulses once, 1 cycle after the last capture. A channel 0 capture coincident with the clear carries into the next frame.
- One-shot:
  - Stimulus: oneshot=1; start pulse, one capture; then done pulses without start.
  - Response: exactly one ch_valid per start; channel returns to IDLE (00) after REARM.
- Reset and enable mid-operation:
  - Stimulus: drop rst_n during RESET.
  - Response: adc_rst=0 immediately (asynchronously); all state=IDLE.
  - Stimulus: drop enable mid-RESET.
  - Response: pulse truncated on the next edge; ch_data retained.
